// File: rtl/edge_generator_if.sv
// Request/level bundle for the edge generator.
// Master drives requests; slave drives the line and status pulses.
interface edge_generator_if;
  logic rise_req;
  logic fall_req;
  logic line_out;
  logic rise_ack;
  logic fall_ack;
  logic drop;
  logic busy;

  modport master (
    output rise_req, fall_req,
    input  line_out, rise_ack, fall_ack, drop, busy
  );

  modport slave (
    input  rise_req, fall_req,
    output line_out, rise_ack, fall_ack, drop, busy
  );
endinterface

// File: rtl/edge_generator.sv
// Level-line generator driven by rise/fall request pulses.
// Enforces dwell times and keeps one early request pending.
module edge_generator #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  edge_generator_if.slave  bus
);

  typedef enum logic [1:0] {
    LOW_IDLE,
    HIGH_HOLD,
    HIGH_IDLE,
    LOW_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(MIN_LOW - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             rack_d, fack_d, drop_d;
  logic             line_q, rack_q, fack_q, drop_q, busy_q;
  logic             rr, fr;

  assign rr = bus.rise_req;
  assign fr = bus.fall_req;

  // Next state, dwell counter, pending flag and pulse decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    rack_d  = 1'b0;
    fack_d  = 1'b0;
    drop_d  = 1'b0;
    if (rr && fr) begin
      // Conflicting pair: reject both, freeze everything
      drop_d = 1'b1;
    end else begin
      unique case (state_q)
        LOW_IDLE: begin
          if (rr) begin
            state_d = HIGH_HOLD;
            cnt_d   = HI_LOAD;
            rack_d  = 1'b1;
          end else if (fr) begin
            drop_d = 1'b1;
          end
        end
        HIGH_IDLE: begin
          if (fr) begin
            state_d = LOW_HOLD;
            cnt_d   = LO_LOAD;
            fack_d  = 1'b1;
          end else if (rr) begin
            drop_d = 1'b1;
          end
        end
        HIGH_HOLD: begin
          drop_d = rr | (fr & pend_q);
          if (cnt_q == ZERO) begin
            if (pend_q || fr) begin
              state_d = LOW_HOLD;
              cnt_d   = LO_LOAD;
              pend_d  = 1'b0;
              fack_d  = 1'b1;
            end else begin
              state_d = HIGH_IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
            if (fr) pend_d = 1'b1;
          end
        end
        LOW_HOLD: begin
          drop_d = fr | (rr & pend_q);
          if (cnt_q == ZERO) begin
            if (pend_q || rr) begin
              state_d = HIGH_HOLD;
              cnt_d   = HI_LOAD;
              pend_d  = 1'b0;
              rack_d  = 1'b1;
            end else begin
              state_d = LOW_IDLE;
            end
          end else begin
            cnt_d = cnt_q - ONE;
            if (rr) pend_d = 1'b1;
          end
        end
        default: state_d = LOW_IDLE;
      endcase
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOW_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      line_q  <= 1'b0;
      rack_q  <= 1'b0;
      fack_q  <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      line_q  <= (state_d == HIGH_HOLD) || (state_d == HIGH_IDLE);
      rack_q  <= rack_d;
      fack_q  <= fack_d;
      drop_q  <= drop_d;
      busy_q  <= (state_d == HIGH_HOLD) || (state_d == LOW_HOLD);
    end
  end

  assign bus.line_out = line_q;
  assign bus.rise_ack = rack_q;
  assign bus.fall_ack = fack_q;
  assign bus.drop     = drop_q;
  assign bus.busy     = busy_q;

endmodule
